// File: rtl/sram_like_to_axi.sv
// Bridges two SRAM-like CPU ports (instruction and data) onto one AXI3 master.
// It carries one single-beat transaction at a time, and the data port wins arbitration.
module sram_like_to_axi (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // AXI read address / data
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t      state;
  logic        sel_data;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;

  logic        req_any;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_fire;
  logic        unused_rid;

  // Byte-lane strobe for a single beat; size 3 is illegal and writes no lanes.
  function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << lo;
      2'd1:    s = lo[1] ? 4'b1100 : 4'b0011;
      2'd2:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  assign req_any   = inst_req | data_req;
  assign req_wr    = data_req ? data_wr    : inst_wr;
  assign req_size  = data_req ? data_size  : inst_size;
  assign req_addr  = data_req ? data_addr  : inst_addr;
  assign req_wdata = data_req ? data_wdata : inst_wdata;

  assign data_addr_ok = rst & (state == IDLE) & data_req;
  assign inst_addr_ok = rst & (state == IDLE) & inst_req & ~data_req;

  // Ready is only high in the matching wait state, so stray responses never complete anything.
  assign resp_fire    = (rready & rvalid) | (bready & bvalid);
  assign inst_data_ok = resp_fire & ~sel_data;
  assign data_data_ok = resp_fire &  sel_data;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid   = {3'b000, sel_data};
  assign araddr = addr_r;
  assign arsize = {1'b0, size_r};
  assign awaddr = addr_r;
  assign awsize = {1'b0, size_r};
  assign wdata  = wdata_r;
  assign wstrb  = wstrb_r;
  assign unused_rid = ^rid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sel_data <= 1'b0;
      size_r   <= 2'd0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      wstrb_r  <= 4'd0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            sel_data <= data_req;
            size_r   <= req_size;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            wstrb_r  <= req_wr ? strb_of(req_size, req_addr[1:0]) : 4'b0000;
            if (req_wr) begin
              state   <= WR_REQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= RD_ADDR;
              arvalid <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end
        WR_REQ: begin
          // AW and W complete independently; wait until both have handshaken.
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_to_axi.sv
// Table-driven bench for sram_like_to_axi with an AXI slave model and a response scoreboard.
`timescale 1ns/1ps
module tb_sram_like_to_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  sram_like_to_axi dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  // dly_a: arready / awready delay, dly_b: rvalid / wready delay, dly_c: bvalid delay
  typedef struct {
    logic        port;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly_a;
    int          dly_b;
    int          dly_c;
    logic [3:0]  exp_strb;
  } vec_t;

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic addr_ok_of(input logic p);
    return p ? data_addr_ok : inst_addr_ok;
  endfunction

  function automatic logic data_ok_of(input logic p);
    return p ? data_data_ok : inst_data_ok;
  endfunction

  function automatic logic [31:0] rdata_of(input logic p);
    return p ? data_rdata : inst_rdata;
  endfunction

  task automatic set_req(input logic port, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd, input logic req);
    if (port) begin
      data_req = req; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = req; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
    end
  endtask

  task automatic pop_compare(input logic port);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: data_ok on port %0d with nothing outstanding", port);
    end else begin
      e = sb.pop_front();
      check("sb_port", port, e.port);
      if (!e.wr) check("sb_rdata", rdata_of(port), e.data);
    end
  endtask

  // Starts and ends just after a falling edge; drops the request and scrambles its fields once accepted.
  task automatic request(input vec_t v);
    int cnt = 0;
    set_req(v.port, v.wr, v.size, v.addr, v.wdata, 1'b1);
    #1;
    while (!addr_ok_of(v.port) && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("addr_ok", addr_ok_of(v.port), 1'b1);
    sb.push_back('{port: v.port, wr: v.wr, data: v.rdata});
    @(negedge clk);
    set_req(v.port, ~v.wr, 2'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic serve_read(input vec_t v);
    for (int k = 0; k <= v.dly_a; k++) begin
      arready = (k == v.dly_a);
      #1;
      check("arvalid", arvalid, 1'b1);
      check("rd_addr_ok_low", inst_addr_ok | data_addr_ok, 1'b0);
      if (k == v.dly_a) begin
        check("araddr", araddr, v.addr);
        check("arsize", arsize, {1'b0, v.size});
        check("arid", arid, {3'b000, v.port});
      end
      @(negedge clk);
    end
    arready = 1'b0;
    for (int j = 0; j <= v.dly_b; j++) begin
      rvalid = (j == v.dly_b);
      rdata  = (j == v.dly_b) ? v.rdata : 32'h0BAD_0BAD;
      #1;
      check("rready", rready, 1'b1);
      check("arvalid_low", arvalid, 1'b0);
      check("rd_addr_ok_low", inst_addr_ok | data_addr_ok, 1'b0);
      check("rd_data_ok", data_ok_of(v.port), (j == v.dly_b));
      check("rd_other_data_ok", data_ok_of(~v.port), 1'b0);
      if (data_ok_of(v.port)) pop_compare(v.port);
      @(negedge clk);
    end
    rvalid = 1'b0;
  endtask

  task automatic serve_write(input vec_t v);
    int last;
    last = (v.dly_a > v.dly_b) ? v.dly_a : v.dly_b;
    for (int k = 0; k <= last; k++) begin
      awready = (k == v.dly_a);
      wready  = (k == v.dly_b);
      #1;
      check("awvalid", awvalid, (k <= v.dly_a));
      check("wvalid", wvalid, (k <= v.dly_b));
      check("bready_low", bready, 1'b0);
      check("wr_data_ok_early", inst_data_ok | data_data_ok, 1'b0);
      check("wr_addr_ok_low", inst_addr_ok | data_addr_ok, 1'b0);
      if (k == 0) begin
        check("awaddr", awaddr, v.addr);
        check("awsize", awsize, {1'b0, v.size});
        check("wstrb", wstrb, v.exp_strb);
        check("wdata", wdata, v.wdata);
      end
      @(negedge clk);
    end
    awready = 1'b0;
    wready  = 1'b0;
    for (int j = 0; j <= v.dly_c; j++) begin
      bvalid = (j == v.dly_c);
      #1;
      check("bready", bready, 1'b1);
      check("aw_w_valid_low", awvalid | wvalid, 1'b0);
      check("wr_data_ok", data_ok_of(v.port), (j == v.dly_c));
      check("wr_other_data_ok", data_ok_of(~v.port), 1'b0);
      if (data_ok_of(v.port)) pop_compare(v.port);
      @(negedge clk);
    end
    bvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dv, iv;
    rst = 1'b0;
    set_req(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1);
    set_req(1'b1, 1'b1, 2'd2, 32'h0, 32'h0, 1'b1);
    arready = 1'b0; rid = 4'd0; rdata = 32'h0; rvalid = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;

    // Outputs held quiet while reset is asserted, even with requests and responses pending.
    repeat (2) @(negedge clk);
    #1;
    check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    check("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    check("rst_readys", {rready, bready}, 2'b00);
    check("rst_wstrb", wstrb, 4'b0000);
    check("rst_araddr", araddr, 32'h0);
    check("rst_awaddr", awaddr, 32'h0);
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    vecs[0] = '{port:1'b0, wr:1'b0, size:2'd2, addr:32'hBFC0_0000, wdata:32'h0, rdata:32'h3C08_0001,
                dly_a:2, dly_b:3, dly_c:0, exp_strb:4'b0000};
    vecs[1] = '{port:1'b1, wr:1'b0, size:2'd2, addr:32'h8000_1000, wdata:32'h0, rdata:32'h1234_5678,
                dly_a:0, dly_b:0, dly_c:0, exp_strb:4'b0000};
    vecs[2] = '{port:1'b1, wr:1'b1, size:2'd0, addr:32'h8000_0003, wdata:32'h5555_5555, rdata:32'h0,
                dly_a:0, dly_b:0, dly_c:2, exp_strb:4'b1000};
    vecs[3] = '{port:1'b1, wr:1'b1, size:2'd1, addr:32'h8000_0002, wdata:32'hAAAA_BBBB, rdata:32'h0,
                dly_a:3, dly_b:0, dly_c:1, exp_strb:4'b1100};
    vecs[4] = '{port:1'b0, wr:1'b1, size:2'd0, addr:32'h0000_0001, wdata:32'h7777_7777, rdata:32'h0,
                dly_a:1, dly_b:1, dly_c:0, exp_strb:4'b0010};
    vecs[5] = '{port:1'b1, wr:1'b1, size:2'd2, addr:32'h0000_0010, wdata:32'hCAFE_F00D, rdata:32'h0,
                dly_a:2, dly_b:0, dly_c:0, exp_strb:4'b1111};
    vecs[6] = '{port:1'b1, wr:1'b1, size:2'd1, addr:32'h0000_0000, wdata:32'h1111_2222, rdata:32'h0,
                dly_a:0, dly_b:2, dly_c:1, exp_strb:4'b0011};
    vecs[7] = '{port:1'b1, wr:1'b1, size:2'd3, addr:32'h0000_0004, wdata:32'h3333_4444, rdata:32'h0,
                dly_a:0, dly_b:0, dly_c:0, exp_strb:4'b0000};
    vecs[8] = '{port:1'b0, wr:1'b0, size:2'd0, addr:32'h1FC0_0004, wdata:32'h0, rdata:32'h8765_4321,
                dly_a:1, dly_b:1, dly_c:0, exp_strb:4'b0000};

    for (int i = 0; i < 9; i++) begin
      request(vecs[i]);
      if (vecs[i].wr) serve_write(vecs[i]);
      else            serve_read(vecs[i]);
    end

    // Simultaneous requests: data port wins, inst waits and is taken on the next IDLE cycle.
    dv = '{port:1'b1, wr:1'b0, size:2'd2, addr:32'h8000_1000, wdata:32'h0, rdata:32'hA5A5_0001,
           dly_a:0, dly_b:1, dly_c:0, exp_strb:4'b0000};
    iv = '{port:1'b0, wr:1'b0, size:2'd2, addr:32'hBFC0_0008, wdata:32'h0, rdata:32'h5A5A_0002,
           dly_a:0, dly_b:0, dly_c:0, exp_strb:4'b0000};
    set_req(1'b0, iv.wr, iv.size, iv.addr, iv.wdata, 1'b1);
    set_req(1'b1, dv.wr, dv.size, dv.addr, dv.wdata, 1'b1);
    #1;
    check("arb_data_addr_ok", data_addr_ok, 1'b1);
    check("arb_inst_addr_ok", inst_addr_ok, 1'b0);
    request(dv);
    serve_read(dv);
    #1;
    check("arb_inst_next_idle", inst_addr_ok, 1'b1);
    request(iv);
    serve_read(iv);

    // Reset in RD_DATA abandons the read; a stray late response is ignored.
    iv.addr = 32'hBFC0_0010;
    request(iv);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1;
    check("mid_rready", rready, 1'b1);
    rst = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_rready", rready, 1'b0);
    check("mid_rst_araddr", araddr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    rvalid = 1'b1;
    bvalid = 1'b1;
    rdata = 32'hFEED_FACE;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("stray_readys", {rready, bready}, 2'b00);
      check("stray_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      @(negedge clk);
    end
    rvalid = 1'b0;
    bvalid = 1'b0;
    iv.addr  = 32'hBFC0_0020;
    iv.rdata = 32'h2408_0005;
    request(iv);
    serve_read(iv);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_to_axi.md
SRAM_LIKE_TO_AXI -- requirements
Module: sram_like_to_axi

Interface
REQ-001 Parameters: none; AXI IDs fixed (inst=4'd0, data=4'd1).
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 inst_req, inst_wr  in  1 each  instruction-port request, write flag.
REQ-005 inst_size  in  2; inst_addr, inst_wdata  in  32 each.
REQ-006 inst_rdata  out  32; inst_addr_ok, inst_data_ok  out  1 each.
REQ-007 data_req, data_wr  in  1 each; data_size  in  2; data_addr, data_wdata  in  32 each.
REQ-008 data_rdata  out  32; data_addr_ok, data_data_ok  out  1 each.
REQ-009 arid  out  4; araddr  out  32; arsize  out  3; arvalid  out  1; arready  in  1.
REQ-010 rid  in  4; rdata  in  32; rvalid  in  1; rready  out  1.
REQ-011 awaddr  out  32; awsize  out  3; awvalid  out  1; awready  in  1.
REQ-012 wdata  out  32; wstrb  out  4; wvalid  out  1; wready  in  1.
REQ-013 bvalid  in  1; bready  out  1.
REQ-014 Other AXI3 fields (len=0, burst=INCR, lock/cache/prot=0, awid/wid=1, wlast=1) tied outside this block.

Function
REQ-015 Single-beat transactions; one transaction in flight total.
REQ-016 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-017 IDLE arbitration: data_req wins over inst_req when both high same cycle.
REQ-018 Winner's *_addr_ok asserted combinationally in IDLE only; loser's addr_ok low.
REQ-019 On addr_ok cycle: latch port select, wr, size, addr, wdata; go RD_ADDR (wr=0) or WR_REQ (wr=1).
REQ-020 *_addr_ok SHALL be 0 in every non-IDLE state.
REQ-021 RD_ADDR: arvalid=1, araddr/arsize/arid from latch; arsize={1'b0,size}; on arready go RD_DATA.
REQ-022 RD_DATA: rready=1; on rvalid: selected *_rdata=rdata, selected *_data_ok=1 for that one cycle, go IDLE.
REQ-023 *_rdata driven combinationally from rdata; valid only when *_data_ok=1.
REQ-024 WR_REQ: awvalid and wvalid both raised; each dropped after own handshake; move to WR_RESP once both done (same or different cycles).
REQ-025 wstrb: size 0 -> 4'b0001<<addr[1:0]; size 1 -> addr[1]?4'b1100:4'b0011; size 2 -> 4'b1111; size 3 -> 4'b0000 (illegal).
REQ-026 wdata = latched wdata unshifted (CPU supplies lane-replicated data).
REQ-027 WR_RESP: bready=1; on bvalid: selected *_data_ok=1 one cycle, go IDLE.
REQ-028 New request accepted earliest cycle after data_ok (IDLE re-entered); no same-cycle data_ok and addr_ok.
REQ-029 Request inputs changing after addr_ok have no effect on the in-flight transaction.
REQ-030 rid/bresp not checked; a response in the wrong state is ignored (rready/bready low).

Reset
REQ-031 rst low: FSM to IDLE immediately, all latched fields 0.
REQ-032 During reset: all valid/ready outputs, addr_ok, data_ok 0; wstrb 0; araddr/awaddr 0.
REQ-033 Reset mid-transaction abandons it; no data_ok issued for it after release.

Verification
REQ-034 Inst read 0xBFC00000 size 2, arready after 2 cycles, rvalid rdata 0x3C080001 after 3 more -> arid=0, arsize=3'b010, inst_data_ok one cycle, inst_rdata=0x3C080001.
REQ-035 inst_req and data_req (read 0x80001000) same cycle -> data_addr_ok=1, inst_addr_ok=0; data read done first, inst accepted next IDLE cycle.
REQ-036 Byte write addr 0x80000003 data 0x55555555 -> awaddr=0x80000003, awsize=0, wstrb=4'b1000; data_data_ok only after bvalid.
REQ-037 Half write addr 0x80000002 with awready 3 cycles after wready -> wvalid drops after W handshake, awvalid held, wstrb=4'b1100, WR_RESP entered after AW handshake.
REQ-038 rst low while in RD_DATA, then released; stray rvalid arrives -> rready=0, no data_ok, next inst_req accepted normally.
